bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It converts an unsigned `WIDTH`-bit value into `DIGITS` packed BCD digits. A start/busy/done handshake lets it sit between a binary datapath (counter, ALU result) and the seven-segment display drivers. It succeeds the fixed 7-bit combinational converter: it supports arbitrary widths without a deep combinational add-3 chain.

---
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking is compiled in with `define BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      x,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int SRW = WIDTH + 4 * DIGITS;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SRW-1:0]  sr;
    logic [SRW-1:0]  sr_adj;
    logic [SRW-1:0]  sr_shift;
    logic [CW-1:0]   cnt;
    logic            last;

    // Handshake: start is taken on any edge where busy is low (the upstream
    // "valid" is start, our "ready" is !busy); done pulses one cycle when bcd
    // is updated, and start in that same cycle is already accepted.
    assign busy = (state == SHIFT);
    assign last = (state == SHIFT) && (cnt == CW'(1));

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH+4*i +: 4] >= 4'd5)
                sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
        end
        sr_shift = sr_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= {{(4*DIGITS){1'b0}}, x};
                        cnt <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    sr  <= sr_shift;
                    cnt <= cnt - CW'(1);
                    // Only the completed digit field is ever exposed on bcd.
                    if (last) begin
                        bcd  <= sr_shift[SRW-1 -: 4*DIGITS];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              run;

    // A digit blanks when it and every digit above it are zero; units never blanks.
    always_comb begin
        blank_nx = '0;
        run      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run         = run & (sr_shift[WIDTH+4*i +: 4] == 4'd0);
            blank_nx[i] = run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank <= {DIGITS{1'b1}} ^ DIGITS'(1);
        else if (last)
            blank <= blank_nx;
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, random conversions at
// 16/5 against an arithmetic reference, and an exhaustive sweep at 7/3.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst, start;
    logic [15:0] x;
    logic        busy, done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    logic        rst7, start7;
    logic [6:0]  x7;
    logic        busy7, done7;
    logic [11:0] bcd7;
    logic [2:0]  blank7;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(busy), .done(done), .bcd(bcd), .blank(blank)
    );

    bin2bcd_seq #(.WIDTH(7), .DIGITS(3)) dut7 (
        .clk(clk), .rst(rst7), .start(start7), .x(x7),
        .busy(busy7), .done(done7), .bcd(bcd7), .blank(blank7)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // reference helpers: plain decimal arithmetic
    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] blank_of(input int unsigned v, input int nd);
        logic [4:0] b;
        int unsigned p;
        b = '0;
        p = 1;
`ifdef BIN2BCD_BLANK_EN
        for (int i = 1; i < nd; i++) begin
            p = p * 10;
            b[i] = (v < p);
        end
`else
        p = p + nd;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: expected-queue model of the 16-bit converter, updated per edge
    logic [15:0] exp_q[$];
    int          due_q[$];
    int          cyc = 0;
    bit          m_valid = 0;
    logic        e_busy, e_done;
    logic [19:0] e_bcd;
    logic [4:0]  e_blank;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            e_done  = 1'b0;
            e_bcd   = '0;
            e_blank = blank_of(0, 5);
            m_valid = 1;
        end else begin
            e_done = 1'b0;
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                e_done  = 1'b1;
                e_bcd   = to_bcd(exp_q[0]);
                e_blank = blank_of(exp_q[0], 5);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end else if (due_q.size() == 0 && start) begin
                exp_q.push_back(x);
                due_q.push_back(cyc + 16);
            end
        end
        e_busy = (due_q.size() != 0);
    end

    // compare process
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("bcd", 32'(bcd), 32'(e_bcd));
            chk("blank", 32'(blank), 32'(e_blank));
            if (done) begin
                for (int i = 0; i < 5; i++)
                    if (bcd[4*i +: 4] > 4'd9) chk("digit_le9", 32'(bcd[4*i +: 4]), 32'd9);
            end
        end
    end

    // driver tasks: called just after a negedge
    task automatic conv(input logic [15:0] v, output int lat);
        x = v;
        start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                lat = c - 1;
                break;
            end
        end
        if (lat < 0) chk("timeout16", 32'hFFFF_FFFF, 32'd16);
    endtask

    task automatic conv7(input logic [6:0] v, output int lat);
        x7 = v;
        start7 = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) start7 = 1'b0;
            if (done7) begin
                lat = c - 1;
                break;
            end
        end
        if (lat < 0) chk("timeout7", 32'hFFFF_FFFF, 32'd7);
    endtask

    initial begin
        int lat;
        int extra;
        rst = 1'b1; start = 1'b0; x = '0;
        rst7 = 1'b1; start7 = 1'b0; x7 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        chk("reset_blank", 32'(blank), 32'b11110);
`else
        chk("reset_blank", 32'(blank), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        conv(16'd12345, lat);
        chk("lat_12345", 32'(lat), 32'd16);
        chk("bcd_12345", 32'(bcd), 32'h12345);
        chk("blank_12345", 32'(blank), 32'd0);

        // second start lands in the done cycle of the first
        conv(16'd0, lat);
        chk("bcd_0", 32'(bcd), 32'h0);
`ifdef BIN2BCD_BLANK_EN
        chk("blank_0", 32'(blank), 32'b11110);
`else
        chk("blank_0", 32'(blank), 32'd0);
`endif
        conv(16'd65535, lat);
        chk("lat_65535", 32'(lat), 32'd16);
        chk("bcd_65535", 32'(bcd), 32'h65535);

        // start and x poked mid-conversion
        @(negedge clk);
        x = 16'd42; start = 1'b1; lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 5) begin start = 1'b1; x = 16'd999; end
            if (c == 6) start = 1'b0;
            if (done) begin lat = c - 1; break; end
        end
        chk("lat_42", 32'(lat), 32'd16);
        chk("bcd_42", 32'(bcd), 32'h00042);
`ifdef BIN2BCD_BLANK_EN
        chk("blank_42", 32'(blank), 32'b11100);
`else
        chk("blank_42", 32'(blank), 32'd0);
`endif
        extra = 0;
        repeat (24) begin @(negedge clk); if (done) extra++; end
        chk("single_done_42", 32'(extra), 32'd0);

        // reset in the middle of a conversion
        x = 16'd500; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        extra = 0;
        repeat (30) begin @(negedge clk); if (done) extra++; end
        chk("abort_no_done", 32'(extra), 32'd0);
        conv(16'd500, lat);
        chk("bcd_500", 32'(bcd), 32'h00500);

        // random conversions with random idle gaps
        for (int n = 0; n < 1000; n++) begin
            conv(16'($urandom_range(0, 65535)), lat);
            chk("lat_rand", 32'(lat), 32'd16);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // exhaustive sweep at WIDTH=7, DIGITS=3
        rst7 = 1'b0;
        @(negedge clk);
        for (int v = 0; v < 128; v++) begin
            conv7(7'(v), lat);
            chk("lat7", 32'(lat), 32'd7);
            chk("bcd7", 32'(bcd7), 32'(to_bcd(v) & 20'hFFF));
            chk("blank7", 32'(blank7), 32'(blank_of(v, 3) & 5'h7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
